pwm_clk_gen: RTL

Parametrised, runtime-programmable clock divider and multi-channel PWM generator, driven from the 50 MHz board clock. One shared period counter sets the divide ratio. Each channel compares against its own duty value, and the block also emits a one-cycle period tick. New divide and duty values are held in shadow registers and applied glitch-free at a period boundary. With default parameters, channel 0 reproduces the existing fixed 3.125 MHz, 50 % clock.

---
 rtl/pwm_clk_gen_if.sv | 36 +++
 rtl/pwm_clk_gen.sv | 106 ++++++++++
 2 files changed

// File: rtl/pwm_clk_gen_if.sv
// pwm_clk_gen_if
//   Groups the control and output signals of pwm_clk_gen so that the
//   divider can be dropped into a design as a single bus.
//
//   en          run enable (1 = run, 0 = hold counter at 0, outputs low)
//   load        one-cycle strobe capturing div_in/duty_in into the shadow
//   div_in      requested period in clk_50M cycles
//   duty_in     requested high time per channel, channel i at [i*CNT_W +: CNT_W]
//   pwm_out     registered PWM outputs, one bit per channel
//   period_tick registered one-cycle pulse per period
//   upd_pend    shadow values captured but not yet applied
//
//   master: the controlling side (drives en/load/div_in/duty_in)
//   slave : the generator itself
interface pwm_clk_gen_if #(
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 2
);
    logic                    en;
    logic                    load;
    logic [CNT_W-1:0]        div_in;
    logic [NUM_CH*CNT_W-1:0] duty_in;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_tick;
    logic                    upd_pend;

    modport master (
        output en, load, div_in, duty_in,
        input  pwm_out, period_tick, upd_pend
    );

    modport slave (
        input  en, load, div_in, duty_in,
        output pwm_out, period_tick, upd_pend
    );
endinterface

// File: rtl/pwm_clk_gen.sv
// pwm_clk_gen
//   Runtime-programmable clock divider and multi-channel PWM generator.
//   A shared period counter sets the divide ratio; each channel compares the
//   counter against its own duty value. New divide/duty values are held in a
//   shadow copy and only take effect at a period boundary (or while disabled),
//   so a running period is never truncated or stretched. With default
//   parameters channel 0 is the legacy 3.125 MHz, 50 % clock.
//
//   clk_50M  system clock, all logic on its rising edge
//   reset    synchronous, active-high reset to the default divide/duty
//   bus      pwm_clk_gen_if slave: en, load, div_in, duty_in in;
//            pwm_out, period_tick, upd_pend out (all registered)
module pwm_clk_gen #(
    parameter int CNT_W    = 8,
    parameter int NUM_CH   = 2,
    parameter int DEF_DIV  = 16,
    parameter int DEF_DUTY = 8
) (
    input logic          clk_50M,
    input logic          reset,
    pwm_clk_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DEF_DUTY);
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  div_act;
    logic [CNT_W-1:0]  div_shd;
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic [CNT_W-1:0]  duty_shd [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
    logic              tick_q;
    logic              pend_q;

    logic [CNT_W-1:0]  div_eff;
    logic              wrap;
    logic              apply;

    // Divide values 0 and 1 are kept as written but run as a 2-cycle period.
    always_comb begin
        div_eff = (div_act < DIV_MIN) ? DIV_MIN : div_act;
        wrap    = (cnt == div_eff - ONE);
        apply   = !bus.en || wrap;
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            div_shd <= DIV_RST;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= DUTY_RST;
                duty_shd[i] <= DUTY_RST;
            end
            pwm_q  <= '0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (bus.en) begin
                cnt    <= wrap ? '0 : cnt + ONE;
                tick_q <= wrap;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    pwm_q[i] <= (cnt < duty_act[i]);
                end
            end else begin
                cnt    <= '0;
                tick_q <= 1'b0;
                pwm_q  <= '0;
            end

            if (bus.load) begin
                div_shd <= bus.div_in;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    duty_shd[i] <= bus.duty_in[i*CNT_W +: CNT_W];
                end
            end

            // A load landing on the apply edge bypasses the shadow so the
            // new values are active immediately and nothing stays pending.
            if (apply) begin
                pend_q <= 1'b0;
                if (bus.load) begin
                    div_act <= bus.div_in;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        duty_act[i] <= bus.duty_in[i*CNT_W +: CNT_W];
                    end
                end else begin
                    div_act <= div_shd;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        duty_act[i] <= duty_shd[i];
                    end
                end
            end else if (bus.load) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.upd_pend    = pend_q;

endmodule
